// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: MSB-first, one bit per cycle, result 2..WIDTH+1 edges after start.
// No backpressure: start is only sampled in IDLE; starts during a compare are dropped.

module serial_mag_cmp_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_swap,
    output logic o_gt,
    output logic o_lt
);
    logic w_x_gt;
    logic w_x_lt;

    assign w_x_gt = i_x & ~i_y;
    assign w_x_lt = ~i_x & i_y;

    // A set sign bit means the smaller value in two's complement.
    assign o_gt = i_swap ? w_x_lt : w_x_gt;
    assign o_lt = i_swap ? w_x_gt : w_x_lt;
endmodule

module serial_mag_comparator #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]   r_idx;
    logic            r_busy;
    logic            r_done;
    logic            r_g;
    logic            r_e;
    logic            r_l;

    logic w_x;
    logic w_y;
    logic w_swap;
    logic w_gt;
    logic w_lt;
    logic w_last;

    assign w_x    = r_a[r_idx];
    assign w_y    = r_b[r_idx];
    assign w_swap = SIGNED && (r_idx == MSB_IDX);
    assign w_last = (r_idx == '0);

    serial_mag_cmp_cell u_cell (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_swap (w_swap),
        .o_gt   (w_gt),
        .o_lt   (w_lt)
    );

    // Operand and index registers are not reset: they are only read in RUN,
    // and RUN is always entered through a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_g     <= 1'b0;
            r_e     <= 1'b0;
            r_l     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= MSB_IDX;
                        r_busy  <= 1'b1;
                        r_g     <= 1'b0;
                        r_e     <= 1'b0;
                        r_l     <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_gt || w_lt || w_last) begin
                        r_g     <= w_gt;
                        r_l     <= w_lt;
                        r_e     <= ~(w_gt | w_lt);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign g    = r_g;
    assign e    = r_e;
    assign l    = r_l;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Runs an unsigned and a signed instance side by side on identical stimulus.
// Expected {g,e,l} and latency are queued at issue and checked when done pulses.

module tb_serial_mag_comparator;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy_u, done_u, g_u, e_u, l_u;
    logic       busy_s, done_s, g_s, e_s, l_s;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] E = 3'b010;
    localparam logic [2:0] L = 3'b001;

    typedef struct {
        int         acc;
        int         lat;
        logic [2:0] ru;
        logic [2:0] rs;
    } exp_t;

    exp_t sbq[$];
    exp_t ent;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   bcnt     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_mag_comparator #(.WIDTH(8), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_u), .done(done_u), .g(g_u), .e(e_u), .l(l_u)
    );

    serial_mag_comparator #(.WIDTH(8), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .g(g_s), .e(e_s), .l(l_s)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each done.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            check("onehot_u", 32'($countones({g_u, e_u, l_u}) <= 1), 1);
            check("onehot_s", 32'($countones({g_s, e_s, l_s}) <= 1), 1);
            check("busy_clear_u", 32'(busy_u && ({g_u, e_u, l_u} != 3'b000)), 0);
            check("busy_clear_s", 32'(busy_s && ({g_s, e_s, l_s} != 3'b000)), 0);
        end
        if (done_u || done_s) begin
            check("done_u", done_u, 1);
            check("done_s", done_s, 1);
            if (sbq.size() == 0) begin
                check("unexpected_done", done_u, 0);
            end else begin
                ent = sbq.pop_front();
                check("latency", cyc - ent.acc + 1, ent.lat);
                check("result_u", {g_u, e_u, l_u}, ent.ru);
                check("result_s", {g_s, e_s, l_s}, ent.rs);
                check("busy_cycles", bcnt, ent.lat - 1);
                check("busy_at_done", busy_u, 0);
            end
            bcnt = 0;
        end else if (busy_u) begin
            bcnt++;
        end else begin
            bcnt = 0;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy_u; i++) @(negedge clk);
        check("timeout_busy", busy_u, 0);
    endtask

    task automatic do_cmp(input logic [7:0] va, input logic [7:0] vb,
                          input logic [2:0] ru, input logic [2:0] rs,
                          input int lat, input bit scramble);
        a     = va;
        b     = vb;
        start = 1'b1;
        sbq.push_back('{cyc + 1, lat, ru, rs});
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            a = 8'hFF;
            b = 8'h00;
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_u, 0);
        check("rst_done", done_u, 0);
        check("rst_gel_u", {g_u, e_u, l_u}, 0);
        check("rst_gel_s", {g_s, e_s, l_s}, 0);
        check("rst_busy_s", busy_s, 0);
        rst = 1'b0;
        @(negedge clk);

        do_cmp(8'hA5, 8'h25, G, L, 2, 0);
        repeat (3) @(negedge clk);
        check("hold_u", {g_u, e_u, l_u}, G);
        check("hold_s", {g_s, e_s, l_s}, L);

        do_cmp(8'h3C, 8'h3C, E, E, 9, 0);
        do_cmp(8'hFF, 8'h01, G, L, 2, 0);
        do_cmp(8'h80, 8'h7F, G, L, 2, 0);
        do_cmp(8'h7F, 8'h80, L, G, 2, 0);
        do_cmp(8'h81, 8'h83, L, L, 8, 0);
        do_cmp(8'h40, 8'h41, L, L, 9, 1);

        // Start held for 10 edges: one compare, then a back-to-back one on the done cycle.
        a     = 8'h10;
        b     = 8'h11;
        start = 1'b1;
        sbq.push_back('{cyc + 1, 9, L, L});
        sbq.push_back('{cyc + 10, 9, L, L});
        repeat (10) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Abort a running compare with reset on its fourth edge.
        a     = 8'h00;
        b     = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_before_abort", busy_u, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy_u, 0);
        check("abort_done", done_u, 0);
        check("abort_gel_u", {g_u, e_u, l_u}, 0);
        check("abort_gel_s", {g_s, e_s, l_s}, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_result", {g_u, e_u, l_u}, 0);

        do_cmp(8'h02, 8'h01, G, G, 8, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter SIGNED, default 0, meaning 0 = unsigned compare and 1 = two's-complement compare.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to compare the current a and b.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand x.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand y.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a comparison is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port g, output, 1 bit: high when a > b.
REQ-012 The block SHALL have port e, output, 1 bit: high when a == b.
REQ-013 The block SHALL have port l, output, 1 bit: high when a < b.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RUN; its reset state is IDLE.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL latch a and b into internal registers and set bit index to WIDTH-1.
REQ-016 On that same edge the block SHALL set busy=1, clear g, e and l to 0, and go to RUN.
REQ-017 In RUN, on each edge the block SHALL compare the latched bit pair at the current index, MSB first, using one bit per cycle and a 1-bit compare cell.
REQ-018 When the bit pair differs, or the index is 0, the block SHALL on that edge: write exactly one of g, e or l to 1; pulse done=1; set busy=0; go to IDLE.
REQ-019 Bit-pair mapping (unsigned, or any bit below the MSB): x=1,y=0 gives g; x=0,y=1 gives l.
REQ-020 When SIGNED=1 and the differing bit is the MSB (sign bit), the mapping SHALL be inverted: x=1,y=0 gives l; x=0,y=1 gives g.
REQ-021 When all bits are equal, the block SHALL set e=1 after the index-0 compare.
REQ-022 When the index is nonzero and the bit pair is equal, the block SHALL decrement the index and stay in RUN.
REQ-023 Let j be the number of equal leading bits before the first difference, or WIDTH-1 if a equals b; done SHALL be high after the (j+2)th rising edge counted from the edge that accepted start.
REQ-024 Minimum latency SHALL be 2 edges and maximum latency WIDTH+1 edges.
REQ-025 done SHALL be high for exactly one cycle.
REQ-026 g, e and l SHALL hold their one-hot result until the next accepted start, and SHALL be all-zero while busy=1.
REQ-027 start while busy=1 SHALL be ignored: no reload and no latency change.
REQ-028 start SHALL be accepted in the same cycle that done=1, because the state is IDLE; this gives back-to-back operation.
REQ-029 Changes on a or b after acceptance SHALL NOT affect the result in progress.
REQ-030 At most one of g, e, l SHALL be 1 in any cycle.

Reset
REQ-031 While rst=1 at an edge, the block SHALL set state to IDLE and busy, done, g, e and l to 0; rst has priority over start.
REQ-032 Reset asserted during RUN SHALL abort the comparison without asserting done; the next start after reset SHALL operate normally.
REQ-033 Internal operand and index registers SHALL NOT be observable, and their reset value is don't-care.

Verification (WIDTH=8)
REQ-034 SIGNED=0, a=8'hA5, b=8'h25, start pulse -> done after 2 edges, g=1, e=0, l=0.
REQ-035 SIGNED=0, a=8'h3C, b=8'h3C -> done after 9 edges, e=1, with busy=1 for exactly 8 cycles before that.
REQ-036 SIGNED=1, a=8'hFF (-1), b=8'h01 -> done after 2 edges, l=1; the same operands with SIGNED=0 -> g=1.
REQ-037 a=8'h10, b=8'h11, start held high for 10 cycles -> exactly one done at edge 9 with l=1; a second compare starts on the done cycle, and extra starts while busy are ignored.
REQ-038 Start with a=8'h00, b=8'h00, assert rst at edge 4 -> busy=0, done never pulses, g=e=l=0; a subsequent start with a=8'h02, b=8'h01 -> g=1 after 8 edges.
